// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the byte-serial memory controller
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2,
        MEM_FETCH = 2'd3
    } mem_state_e;

    localparam logic [31:0] IO_BASE_ADDR     = 32'h0003_0000;
    localparam int unsigned IO_SPAN_BYTES    = 8;
    localparam int          MEM_BYTE_CNT_BIT = 3;

    // Widths other than 1 or 2 bytes are serviced as a full word.
    function automatic logic [MEM_BYTE_CNT_BIT-1:0] byte_count(input logic [2:0] width);
        case (width)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - RAM port, LSB and ifetch signal bundle of the memory controller
interface mem_ctrl_if;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        go_work;
    logic        l_or_s;
    logic [2:0]  width;
    logic [31:0] address;
    logic [31:0] value_store;
    logic        received;
    logic        has_result;
    logic [31:0] value_load;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;

    modport slave (
        input  mem_din, go_work, l_or_s, width, address, value_store, if_req, if_addr,
        output mem_dout, mem_a, mem_wr, received, has_result, value_load, if_ready, if_data
    );

    modport master (
        output mem_din, go_work, l_or_s, width, address, value_store, if_req, if_addr,
        input  mem_dout, mem_a, mem_wr, received, has_result, value_load, if_ready, if_data
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates LSB/ifetch and serialises them onto the byte-wide RAM/IO port
// Optional MEM_CTRL_IO_STALL_EN: hold IO-region store bytes while io_buffer_full is high.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_ADDR,
    parameter int unsigned IO_SPAN = IO_SPAN_BYTES
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    input  logic      io_buffer_full,
    input  logic      clear_all,
    mem_ctrl_if.slave bus
);

    mem_state_e                  state_q, state_d;
    logic [MEM_BYTE_CNT_BIT-1:0] cnt_q, cnt_d;
    logic [MEM_BYTE_CNT_BIT-1:0] nbytes_q, nbytes_d;
    logic [31:0]                 addr_q, addr_d;
    logic [31:0]                 wdata_q, wdata_d;
    logic [31:0]                 data_q, data_d;
    logic [31:0]                 prev_a_q;
    logic                        received_q, received_d;
    logic                        has_result_q, has_result_d;
    logic                        if_ready_q, if_ready_d;
    logic [31:0]                 value_load_q, value_load_d;
    logic [31:0]                 if_data_q, if_data_d;

    logic [31:0] cur_a;
    logic [1:0]  rd_idx;
    logic        in_io;
    logic        stall;

    // Loads stop addressing once all bytes are issued, so IO reads never repeat.
    always_comb begin
        cur_a = '0;
        case (state_q)
            MEM_STORE:           cur_a = addr_q + 32'(cnt_q);
            MEM_LOAD, MEM_FETCH: if (cnt_q < nbytes_q) cur_a = addr_q + 32'(cnt_q);
            default:             ;
        endcase
    end

    assign in_io = (cur_a - IO_BASE) < IO_SPAN;

`ifdef MEM_CTRL_IO_STALL_EN
    assign stall = (state_q == MEM_STORE) && in_io && io_buffer_full;
`else
    logic io_unused;
    assign io_unused = in_io & io_buffer_full;
    assign stall     = 1'b0;
`endif

    // While frozen, re-present the last issued address so mem_din still carries
    // the byte the counter is waiting for when rdy_in returns.
    assign bus.mem_a      = rdy_in ? cur_a : prev_a_q;
    assign bus.mem_wr     = rdy_in && (state_q == MEM_STORE) && !stall;
    assign bus.mem_dout   = (state_q == MEM_STORE) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
    assign bus.received   = received_q & rdy_in;
    assign bus.has_result = has_result_q & rdy_in;
    assign bus.if_ready   = if_ready_q & rdy_in;
    assign bus.value_load = value_load_q;
    assign bus.if_data    = if_data_q;

    assign rd_idx = 2'(cnt_q - 3'd1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        nbytes_d     = nbytes_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        received_d   = 1'b0;
        has_result_d = 1'b0;
        if_ready_d   = 1'b0;
        value_load_d = value_load_q;
        if_data_d    = if_data_q;
        case (state_q)
            MEM_IDLE: begin
                if (!clear_all) begin
                    if (bus.go_work) begin
                        state_d    = bus.l_or_s ? MEM_STORE : MEM_LOAD;
                        addr_d     = bus.address;
                        nbytes_d   = byte_count(bus.width);
                        wdata_d    = bus.value_store;
                        cnt_d      = '0;
                        data_d     = '0;
                        received_d = 1'b1;
                    end else if (bus.if_req) begin
                        state_d  = MEM_FETCH;
                        addr_d   = bus.if_addr;
                        nbytes_d = 3'd4;
                        cnt_d    = '0;
                        data_d   = '0;
                    end
                end
            end
            MEM_LOAD, MEM_FETCH: begin
                if (clear_all) begin
                    state_d = MEM_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != '0) data_d[{rd_idx, 3'b000} +: 8] = bus.mem_din;
                    if (cnt_q == nbytes_q) begin
                        state_d = MEM_IDLE;
                        cnt_d   = '0;
                        if (state_q == MEM_LOAD) begin
                            has_result_d = 1'b1;
                            value_load_d = data_d;
                        end else begin
                            if_ready_d = 1'b1;
                            if_data_d  = data_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            MEM_STORE: begin
                if (!stall) begin
                    if (cnt_q == nbytes_q - 3'd1) begin
                        state_d = MEM_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= MEM_IDLE;
            cnt_q        <= '0;
            nbytes_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_q       <= '0;
            prev_a_q     <= '0;
            received_q   <= 1'b0;
            has_result_q <= 1'b0;
            if_ready_q   <= 1'b0;
            value_load_q <= '0;
            if_data_q    <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nbytes_q     <= nbytes_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            prev_a_q     <= cur_a;
            received_q   <= received_d;
            has_result_q <= has_result_d;
            if_ready_q   <= if_ready_d;
            value_load_q <= value_load_d;
            if_data_q    <= if_data_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized transaction-level bench for mem_ctrl
module tb_mem_ctrl;

    logic clk_in = 1'b0;
    logic rst_in, rdy_in, io_buffer_full, clear_all;
    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .io_buffer_full (io_buffer_full),
        .clear_all      (clear_all),
        .bus            (bus)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] ram [bit [31:0]];
    logic [7:0] pre [bit [31:0]];
    logic [7:0] mdl [bit [31:0]];
    int checks   = 0;
    int failures = 0;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        if (pre.exists(a)) return pre[a];
        return 8'h00;
    endfunction

    function automatic logic [7:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : 8'h00;
    endfunction

    // Byte-wide synchronous RAM: data for mem_a appears on mem_din the next cycle.
    always @(posedge clk_in) begin
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
        bus.mem_din <= ram_rd(bus.mem_a);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            pre[a + 32'(k)] = v[8*k +: 8];
            mdl[a + 32'(k)] = v[8*k +: 8];
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_wr"}, bus.mem_wr, 0);
        check_eq({tag, "_a"}, bus.mem_a, 0);
        check_eq({tag, "_dout"}, bus.mem_dout, 0);
        check_eq({tag, "_pulses"}, {bus.received, bus.has_result, bus.if_ready}, 0);
        check_eq({tag, "_vload"}, bus.value_load, 0);
        check_eq({tag, "_ifdata"}, bus.if_data, 0);
    endtask

    // kind: 0 load, 1 store, 2 fetch. Starts in an idle cycle, ends in the first cycle
    // the controller can accept again. Expectations are tracked as the number of
    // ready cycles elapsed since the accept (s).
    task automatic run_txn(input int kind, input logic [2:0] wid, input logic [31:0] a,
                           input logic [31:0] v, input int clr_step, input int frz_pct,
                           input int frz_at);
        int n, s, last, nfrz;
        bit done, abort;
        logic [31:0] exp;
        string nm;
        n    = (kind == 2 || !(wid == 3'd1 || wid == 3'd2)) ? 4 : int'(wid);
        last = (kind == 1) ? n + 1 : n + 2;
        exp  = '0;
        for (int k = 0; k < n; k++) begin
            if (kind == 1) mdl[a + 32'(k)] = v[8*k +: 8];
            else exp[8*k +: 8] = mdl_rd(a + 32'(k));
        end
        nm = (kind == 0) ? "ld" : (kind == 1) ? "st" : "if";
        rdy_in    = 1'b1;
        clear_all = 1'b0;
        if (kind == 2) begin
            bus.if_req  = 1'b1;
            bus.if_addr = a;
        end else begin
            bus.go_work     = 1'b1;
            bus.l_or_s      = (kind == 1);
            bus.width       = wid;
            bus.address     = a;
            bus.value_store = v;
        end
        s = 0; nfrz = 0; done = 0; abort = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            next_cycle();
            if (rdy_in) s++;
            if (s == clr_step && !abort) rdy_in = 1'b1;
            else if (s == frz_at && nfrz < 2) begin
                rdy_in = 1'b0;
                nfrz++;
            end else rdy_in = (int'($urandom_range(99)) >= frz_pct);
            clear_all = (s == clr_step) && rdy_in && !abort;
            if (s >= 2) bus.go_work = 1'b0;
            if (kind == 2) bus.if_req = !(abort || (s == last && rdy_in));
            #1;
            if (!rdy_in) begin
                check_eq({nm, "_frz_wr"}, bus.mem_wr, 0);
                check_eq({nm, "_frz_pulse"}, {bus.received, bus.has_result, bus.if_ready}, 0);
            end else begin
                check_eq({nm, "_received"}, bus.received, (kind != 2 && s == 1));
                if (kind == 1) begin
                    check_eq("st_pulses", {bus.has_result, bus.if_ready}, 0);
                    if (s <= n) begin
                        check_eq("st_wr", bus.mem_wr, 1);
                        check_eq("st_a", bus.mem_a, a + 32'(s - 1));
                        check_eq("st_dout", bus.mem_dout, v[8*(s-1) +: 8]);
                    end else begin
                        check_eq("st_idle_wr", bus.mem_wr, 0);
                        done = 1;
                    end
                end else if (abort) begin
                    check_eq({nm, "_abort_pulse"}, {bus.has_result, bus.if_ready}, 0);
                    done = 1;
                end else begin
                    if (s <= n) begin
                        check_eq({nm, "_a"}, bus.mem_a, a + 32'(s - 1));
                        check_eq({nm, "_wr"}, bus.mem_wr, 0);
                    end
                    check_eq({nm, "_has_result"}, bus.has_result, (kind == 0 && s == last));
                    check_eq({nm, "_if_ready"}, bus.if_ready, (kind == 2 && s == last));
                    if (s == last) begin
                        check_eq({nm, "_data"}, (kind == 0) ? bus.value_load : bus.if_data, exp);
                        done = 1;
                    end
                    if (s == clr_step) abort = 1;
                end
            end
        end
        if (!done) check_eq({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        int kind, clr;
        rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; clear_all = 1'b0;
        bus.go_work = 1'b0; bus.l_or_s = 1'b0; bus.width = 3'd0; bus.address = '0;
        bus.value_store = '0; bus.if_req = 1'b0; bus.if_addr = '0;
        #2;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;

        preload(32'h1000, 32'h4433_2211, 4);
        preload(32'h2000, 32'h0000_BEEF, 2);
        run_txn(0, 3'd4, 32'h1000, 0, 0, 0, 0);
        run_txn(1, 3'd1, 32'h20, 32'h1ABC_DEF5, 0, 0, 0);
        run_txn(0, 3'd2, 32'h2000, 0, 0, 0, 2);

        bus.if_req  = 1'b1;
        bus.if_addr = 32'h1000;
        run_txn(0, 3'd1, 32'h20, 0, 0, 0, 0);
        run_txn(2, 3'd4, 32'h1000, 0, 0, 0, 0);

        run_txn(2, 3'd4, 32'h1000, 0, 3, 0, 0);
        run_txn(1, 3'd4, 32'h1100, 32'hA1B2_C3D4, 2, 0, 0);
        run_txn(0, 3'd4, 32'h1100, 0, 0, 0, 0);
        run_txn(1, 3'd4, 32'hFFFF_FFFE, 32'h7788_99AA, 0, 0, 0);
        run_txn(0, 3'd4, 32'hFFFF_FFFE, 0, 0, 0, 0);
        run_txn(0, 3'd5, 32'h1000, 0, 0, 0, 0);

        bus.go_work = 1'b1; bus.l_or_s = 1'b0; bus.width = 3'd1; bus.address = 32'h1000;
        clear_all = 1'b1;
        next_cycle();
        clear_all = 1'b0;
        #1 check_eq("clr_idle_rcv", bus.received, 0);
        run_txn(0, 3'd1, 32'h1000, 0, 0, 0, 0);

`ifdef MEM_CTRL_IO_STALL_EN
        bus.go_work = 1'b1; bus.l_or_s = 1'b1; bus.width = 3'd1;
        bus.address = 32'h0003_0000; bus.value_store = 32'h0000_005A;
        io_buffer_full = 1'b1;
        mdl[32'h0003_0000] = 8'h5A;
        next_cycle();
        bus.go_work = 1'b0;
        #1 check_eq("io_rcv", bus.received, 1);
        check_eq("io_hold1", bus.mem_wr, 0);
        for (int i = 2; i <= 3; i++) begin
            next_cycle();
            #1 check_eq("io_hold", bus.mem_wr, 0);
        end
        next_cycle();
        io_buffer_full = 1'b0;
        #1 check_eq("io_wr", bus.mem_wr, 1);
        check_eq("io_a", bus.mem_a, 32'h0003_0000);
        check_eq("io_dout", bus.mem_dout, 8'h5A);
        next_cycle();
        #1 check_eq("io_done", bus.mem_wr, 0);
`else
        io_buffer_full = 1'b1;
        run_txn(1, 3'd1, 32'h0003_0000, 32'h0000_005A, 0, 0, 0);
`endif
        io_buffer_full = 1'b1;
        run_txn(0, 3'd1, 32'h0003_0000, 0, 0, 0, 0);
        io_buffer_full = 1'b0;

        bus.go_work = 1'b1; bus.l_or_s = 1'b1; bus.width = 3'd4;
        bus.address = 32'h5000; bus.value_store = 32'hCAFE_BABE;
        next_cycle();
        #1 check_eq("rst_pre_wr0", bus.mem_wr, 1);
        next_cycle();
        bus.go_work = 1'b0;
        #1 check_eq("rst_pre_a1", bus.mem_a, 32'h5001);
        #2 rst_in = 1'b0;
        #1 check_outputs_zero("rst_mid");
        next_cycle();
        rst_in = 1'b1;
        check_eq("rst_byte0", ram_rd(32'h5000), 8'hBE);
        check_eq("rst_byte1", ram.exists(32'h5001), 0);

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(2));
            clr  = ($urandom_range(4) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_txn(kind, 3'($urandom_range(7)), 32'h1000 + $urandom_range(255), $urandom,
                    clr, 20, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Downstream of the load/store buffer and the instruction fetch unit; sole owner of the byte-wide unified RAM/IO port.
- Arbitrates between one LSB request and one ifetch request.
- Serialises 1/2/4-byte loads, stores and 4-byte fetches into byte transactions.
- Returns assembled little-endian data with single-cycle pulses.

Parameters:
- IO_BASE, 32'h00030000, first address of the memory-mapped IO region.
- IO_SPAN, 8, number of IO bytes subject to the io_buffer_full stall.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global ready; low freezes the block
- mem_din  input  8  RAM read data, valid the cycle after mem_a
- mem_dout  output  8  RAM write data
- mem_a  output  32  RAM byte address
- mem_wr  output  1  1 = write this cycle
- io_buffer_full  input  1  UART buffer full
- go_work  input  1  LSB request, level; held until received
- l_or_s  input  1  0 = load, 1 = store
- width  input  3  byte count: 1, 2 or 4
- address  input  32  LSB byte address
- value_store  input  32  store data, low bytes used
- received  output  1  one-cycle pulse: LSB request accepted
- has_result  output  1  one-cycle pulse: load data valid
- value_load  output  32  load data, zero-extended
- if_req  input  1  fetch request, level; held until if_ready
- if_addr  input  32  fetch address
- if_ready  output  1  one-cycle pulse: if_data valid
- if_data  output  32  fetched instruction
- clear_all  input  1  pipeline flush

Behaviour:
- Reset (async, rst_in=0):
  - State IDLE.
  - All outputs 0: mem_wr, mem_a, mem_dout, received, has_result, value_load, if_ready, if_data.
  - Byte counter 0, assembled data register 0.
- rdy_in=0: all state, counters and registers hold; mem_wr forced 0; pulses not issued. Pulses pending at freeze are emitted on the first ready cycle.
- States: IDLE, LOAD, STORE, FETCH.
- IDLE arbitration at cycle T:
  - go_work has priority over if_req.
  - Latch address, width, l_or_s and value_store (or if_addr with width 4).
  - Next state is LOAD, STORE or FETCH.
  - LSB accept: received=1 in cycle T+1 only.
  - A request is never accepted outside IDLE, so a held go_work cannot be accepted twice.
- LOAD/FETCH, n bytes:
  - Cycle T+1+k, k=0..n-1: mem_a = addr+k, mem_wr=0.
  - Byte k is sampled from mem_din in cycle T+2+k into bits [8k+7:8k].
  - Cycle T+2+n: has_result=1 (LOAD) or if_ready=1 (FETCH) with data; state returns to IDLE in the same cycle.
  - Total latency n+2 cycles from accept; a new accept is possible in cycle T+2+n.
  - Unused upper bytes are 0; the LSB performs sign extension.
- STORE, n bytes:
  - Cycle T+1+k: mem_a = addr+k, mem_dout = value_store[8k+7:8k], mem_wr=1.
  - After byte n-1, return to IDLE.
  - No completion pulse is generated.
- Address arithmetic is 32-bit wrapping (addr+k mod 2^32).
- clear_all (sampled while rdy_in=1):
  - LOAD or FETCH: abort to IDLE next cycle, suppress has_result/if_ready, clear the counter.
  - STORE: never aborted, because stores are committed at ROB head; the write completes.
  - IDLE with clear_all high: no request is accepted that cycle.
- A reset asserted mid-transaction aborts immediately; mem_wr drops asynchronously.
- width values other than 1, 2 or 4 are treated as 4.

Optional Feature:
- Macro MEM_CTRL_IO_STALL_EN.
- Defined:
  - In STORE, a byte whose address lies in [IO_BASE, IO_BASE+IO_SPAN) is held while io_buffer_full=1: mem_wr=0, counter frozen.
  - The byte is issued in the first cycle io_buffer_full=0.
  - IO loads are unaffected.
- Undefined: io_buffer_full is ignored and stores never stall.

Decomposition:
- const.v additions:
  - MEM_IDLE, MEM_LOAD, MEM_STORE, MEM_FETCH state encodings, 2 bits.
  - IO_BASE_ADDR.
  - MEM_BYTE_CNT_BIT = 3.
- Single module; no sub-module is warranted. Arbitration is a two-input fixed-priority choice inlined in IDLE.

Test Plan:
- LW at 0x1000, RAM bytes 11 22 33 44: received at T+1, mem_a 0x1000..0x1003 in T+1..T+4, has_result at T+6 with value_load=0x44332211.
- SB 0x1ABCDEF5 to 0x20: single mem_wr cycle at T+1 with mem_a=0x20 and mem_dout=0xF5; IDLE at T+2; no has_result.
- go_work and if_req asserted together: LSB load served first; fetch accepted on the cycle the load completes; if_ready carries the 4-byte instruction.
- clear_all during the third byte of a fetch: no if_ready; IDLE next cycle. clear_all during SW: all 4 mem_wr bytes still issued.
- With MEM_CTRL_IO_STALL_EN, SB to 0x30000 with io_buffer_full=1 for 3 cycles: mem_wr=0 for those 3 cycles, then one write of the byte.
- rdy_in low for 2 cycles mid-LH: mem_wr=0, counter holds; result 0x0000BEEF is delivered 2 cycles later than nominal. rst_in low mid-store: all outputs 0 immediately.
